// File: rtl/softmax_grad_collector_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// softmax_grad_collector_if
// Gradient stream from the collector to the output-layer weight update.
// Rev 1.0
// ============================================================================
interface softmax_grad_collector_if #(
    parameter int IDX_WIDTH = 4
);
    logic                 grad_valid;
    logic                 grad_ready;
    logic [31:0]          grad_data;
    logic [IDX_WIDTH-1:0] grad_idx;
    logic                 grad_last;

    modport master (
        output grad_valid,
        output grad_data,
        output grad_idx,
        output grad_last,
        input  grad_ready
    );

    modport slave (
        input  grad_valid,
        input  grad_data,
        input  grad_idx,
        input  grad_last,
        output grad_ready
    );
endinterface
`default_nettype wire

// File: rtl/softmax_grad_collector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// softmax_grad_collector
// Reads back softmax gradients, converts sign-magnitude to two's complement,
// streams them out and keeps accuracy counters. Macro GRAD_SCALE_EN enables
// an arithmetic right shift by LR_SHIFT on stored gradients.
// Rev 1.0
// ============================================================================
module softmax_grad_collector #(
    parameter int WIDTH     = 10,
    parameter int IDX_WIDTH = 4,
    parameter int CNT_WIDTH = 16,
    parameter int LR_SHIFT  = 4
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 go,
    input  wire logic                 sm_out_ready,
    input  wire logic [IDX_WIDTH-1:0] sm_max,
    input  wire logic                 sm_max_ready,
    input  wire logic [IDX_WIDTH-1:0] sm_out_idx,
    input  wire logic [31:0]          sm_out_data,
    input  wire logic [IDX_WIDTH-1:0] label,
    output logic                      sm_start,
    output logic                      sm_backprop_ctrl,
    output logic                      busy,
    output logic                      seq_err,
    output logic [CNT_WIDTH-1:0]      sample_cnt,
    output logic [CNT_WIDTH-1:0]      correct_cnt,
    softmax_grad_collector_if.master  gs
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
`ifdef GRAD_SCALE_EN
    localparam int SHIFT_AMT = LR_SHIFT;
`else
    // Shared shifter; the unscaled build simply shifts by zero.
    localparam int SHIFT_AMT = 0 * LR_SHIFT;
`endif

    state_t               state;
    state_t               state_nxt;
    logic [IDX_WIDTH-1:0] cap_cnt;
    logic [31:0]          grad_buf [WIDTH];

    logic                 accept;
    logic                 handshake;
    logic                 cap_done;
    logic [IDX_WIDTH-1:0] rd_inc;
    logic [31:0]          mag;
    logic [31:0]          conv_full;
    logic [31:0]          conv_val;

    assign accept    = go & sm_out_ready & sm_max_ready;
    assign handshake = gs.grad_valid & gs.grad_ready;
    assign cap_done  = (state == CAPTURE) && (cap_cnt == LAST_IDX);
    assign rd_inc    = gs.grad_idx + IDX_WIDTH'(1);

    // Negative zero falls out as 0 because -0 == 0 in two's complement.
    assign mag       = {1'b0, sm_out_data[30:0]};
    assign conv_full = sm_out_data[31] ? (32'd0 - mag) : mag;
    assign conv_val  = 32'($signed(conv_full) >>> SHIFT_AMT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ARM;
            ARM:     state_nxt = WAIT;
            WAIT:    state_nxt = CAPTURE;
            CAPTURE: if (cap_cnt == LAST_IDX) state_nxt = DRAIN;
            DRAIN:   if (handshake && gs.grad_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            sm_start         <= 1'b0;
            sm_backprop_ctrl <= 1'b0;
            busy             <= 1'b0;
            seq_err          <= 1'b0;
            sample_cnt       <= '0;
            correct_cnt      <= '0;
            cap_cnt          <= '0;
            gs.grad_valid    <= 1'b0;
            gs.grad_data     <= '0;
            gs.grad_idx      <= '0;
            gs.grad_last     <= 1'b0;
        end else begin
            state            <= state_nxt;
            sm_start         <= (state_nxt == ARM) || (state_nxt == CAPTURE);
            sm_backprop_ctrl <= (state_nxt == ARM) || (state_nxt == WAIT) ||
                                (state_nxt == CAPTURE);
            busy             <= (state_nxt != IDLE);

            if (state == IDLE && accept) begin
                if (sample_cnt != CNT_MAX)
                    sample_cnt <= sample_cnt + CNT_WIDTH'(1);
                if (sm_max == label && correct_cnt != CNT_MAX)
                    correct_cnt <= correct_cnt + CNT_WIDTH'(1);
            end

            if (state == WAIT)
                cap_cnt <= '0;
            else if (state == CAPTURE)
                cap_cnt <= cap_cnt + IDX_WIDTH'(1);

            if (state == CAPTURE && sm_out_idx != cap_cnt)
                seq_err <= 1'b1;

            // Word 0 is loaded on the final capture edge; bypass covers WIDTH==1.
            if (cap_done) begin
                gs.grad_valid <= 1'b1;
                gs.grad_idx   <= '0;
                gs.grad_data  <= (LAST_IDX == '0) ? conv_val : grad_buf[0];
                gs.grad_last  <= (LAST_IDX == '0);
            end else if (state == DRAIN && handshake) begin
                if (gs.grad_last) begin
                    gs.grad_valid <= 1'b0;
                    gs.grad_last  <= 1'b0;
                end else begin
                    gs.grad_idx   <= rd_inc;
                    gs.grad_data  <= grad_buf[rd_inc];
                    gs.grad_last  <= (rd_inc == LAST_IDX);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == CAPTURE)
            grad_buf[cap_cnt] <= conv_val;
    end

endmodule
`default_nettype wire
